d_input_debouncer: RTL and testbench
====================================

// Module: d_input_debouncer
// PURPOSE
//  Input-conditioning stage directly upstream of d_latch: takes a raw asynchronous level
//  (switch/pin), synchronises it into the clk domain and debounces it.
//  Its debounced level drives the latch's d input; one-cycle rise/fall pulses go to control logic.
//  Glitches shorter than DEBOUNCE_CYCLES sampled clocks never reach the output.
// PARAMETERS
//  SYNC_STAGES      2   flip-flop stages in input synchroniser; legal 2..4
//  DEBOUNCE_CYCLES  16  consecutive clk samples at new level before output changes; legal >= 2
//  INIT_LEVEL       0   output level and assumed input level while/after reset; 0 or 1
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  reset        in   1  asynchronous, active-low reset (asserted when 0)
//  din_raw      in   1  raw asynchronous input level
//  d            out  1  debounced level, registered; feeds d_latch.d
//  rise_pulse   out  1  registered one-cycle pulse when d goes 0->1
//  fall_pulse   out  1  registered one-cycle pulse when d goes 1->0
//  stable       out  1  1 when FSM in a STABLE state (no candidate change pending)
// BEHAVIOUR
//  Reset (reset==0, async, immediate):
//  - All sync flops = INIT_LEVEL.
//  - d = INIT_LEVEL; rise_pulse = fall_pulse = 0; stable = 1; cnt = 0.
//  - State = STABLE_HI if INIT_LEVEL else STABLE_LO.
//  - Reset mid-check discards the pending candidate; no pulse is emitted.
//  Synchroniser: s = din_raw delayed through SYNC_STAGES flops; FSM sees only s, never din_raw.
//  Counter cnt: width $clog2(DEBOUNCE_CYCLES+1), unsigned, never wraps (cleared on every exit).
//  FSM (4 states):
//  - STABLE_LO: s==1 -> CHECK_HI, cnt<=1; else hold.
//  - CHECK_HI, s==0: -> STABLE_LO, cnt<=0; glitch rejected, d unchanged, no pulse.
//  - CHECK_HI, s==1, cnt==DEBOUNCE_CYCLES-1: -> STABLE_HI, d<=1, rise_pulse<=1, cnt<=0.
//  - CHECK_HI, s==1, otherwise: cnt<=cnt+1.
//  - STABLE_HI / CHECK_LO: mirror image, with s==0 as the candidate level; emits fall_pulse.
//  Outputs:
//  - rise_pulse/fall_pulse high for exactly one cycle, on the same edge d changes.
//  - Never both high; 0 in every other cycle.
//  - stable = 0 in CHECK_HI/CHECK_LO.
//  Latency:
//  - d changes exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that
//    samples din_raw at the new level, provided din_raw holds.
//  - Example: 2+16 = 18 edges.
//  Boundary cases:
//  - Input returns to old level on the last sample before commit: rejected; the count restarts
//    from 1 on the next change.
//  - A bounce restarts the count; there is no accumulation across bounces.
//  - Continuous toggling faster than DEBOUNCE_CYCLES: d never changes and stable stays
//    mostly 0.
// STRUCTURE
//  debounce_pkg:
//  - typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} db_state_t.
//  - Function cnt_width(n) returning $clog2(n+1).
//  Sub-module sync_chain #(STAGES, INIT) (clk, reset, a_in, s_out):
//  - Reusable multi-flop synchroniser, same async active-low reset.
//  Top level: sync_chain, FSM next-state/output always_ff, and counter.
//  - All outputs come straight from flops; no combinational output path.
// TESTING (bench params SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=0, 10 ns clk)
//  1. Reset: hold reset=0 30 ns with din_raw toggling -> d=0, pulses 0, stable=1 throughout.
//  2. Clean rise: din_raw 0->1 and held -> d=1 at edge 6 after first sampling edge;
//     rise_pulse=1 that cycle only; stable=0 during edges 3..5.
//  3. Glitch: din_raw=1 for 3 clocks, then 0 -> d stays 0, no pulse, stable back to 1;
//     repeat with 1-clock glitch, same result.
//  4. Bounce then settle: din_raw 1,0,1,1,0,1 per clk, then held 1 -> d rises 6 edges after
//     the final 0->1 sample; exactly one rise_pulse.
//  5. Clean fall from d=1: din_raw held 0 -> d=0 after 6 edges, fall_pulse one cycle,
//     rise_pulse stays 0.
//  6. Reset mid-check: assert reset=0 while in CHECK_HI (cnt=2) -> d=0, cnt=0, stable=1
//     immediately (async); after release with din_raw=1, full 6-edge latency again.

Source files
------------

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and helpers for the input debouncer.
//  - db_state_t      : 4-state debounce FSM encoding
//  - cnt_width()     : width of a counter that must hold values 0..n
//  - is_stable_state : true for the two settled states
// -----------------------------------------------------------------------------
package debounce_pkg;

   // Settled states (STABLE_*) and candidate-change states (CHECK_*).
   // CHECK_HI means "output is low, input looks high, counting agreement".
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } db_state_t;

   // Bits needed to represent every value 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic logic is_stable_state(input db_state_t st);
      return (st == STABLE_LO) || (st == STABLE_HI);
   endfunction

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Reusable multi-flop synchroniser bringing an asynchronous level into the clk
// domain. a_in passes through STAGES back-to-back flops; s_out is the last one.
// Parameters:
//  STAGES  number of flops, 2..4
//  INIT    level loaded into every flop during reset
// Ports:
//  clk     clock, rising edge
//  reset   asynchronous, active-low reset
//  a_in    raw asynchronous input
//  s_out   synchronised level (registered)
// -----------------------------------------------------------------------------
module sync_chain #(
   parameter int STAGES = 2,
   parameter bit INIT   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic a_in,
   output logic s_out
);

   logic [STAGES-1:0] ff;

   // Flops are preset to INIT so the debouncer sees the assumed input level
   // right after reset instead of a spurious edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ff <= {STAGES{INIT}};
      end else begin
         // NOTE: non-blocking assignment makes every stage sample its
         // predecessor's old value, so this shifts by exactly one flop per edge.
         ff <= {ff[STAGES-2:0], a_in};
      end
   end

   assign s_out = ff[STAGES-1];

endmodule : sync_chain

// File: rtl/d_input_debouncer.sv
// -----------------------------------------------------------------------------
// d_input_debouncer
// Input-conditioning stage ahead of d_latch. A raw asynchronous level is
// synchronised into clk and debounced: the output only changes after the
// synchronised input has held a new level for DEBOUNCE_CYCLES consecutive
// clocks. Any return to the old level during the check discards the candidate
// and a later attempt starts counting from 1 again.
// Parameters:
//  SYNC_STAGES      synchroniser depth, 2..4
//  DEBOUNCE_CYCLES  consecutive agreeing samples needed to commit, >= 2
//  INIT_LEVEL       output / assumed input level during and after reset
// Ports:
//  clk          clock, rising edge
//  reset        asynchronous, active-low reset
//  din_raw      raw asynchronous level
//  d            debounced level (registered), feeds d_latch.d
//  rise_pulse   one-cycle pulse on the edge d goes 0->1 (registered)
//  fall_pulse   one-cycle pulse on the edge d goes 1->0 (registered)
//  stable       1 while no candidate change is pending (registered)
// Latency: d follows a held input change SYNC_STAGES+DEBOUNCE_CYCLES edges
// after the edge that first samples it, counting that edge as the first.
// -----------------------------------------------------------------------------
module d_input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit INIT_LEVEL      = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din_raw,
   output logic d,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic stable
);

   localparam int            CW          = cnt_width(DEBOUNCE_CYCLES);
   // Count value seen on the cycle the final agreeing sample arrives.
   localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam db_state_t     RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

   logic          s;
   db_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          d_nxt, rise_nxt, fall_nxt, stable_nxt;

   // ---------------------------------------------------------------------------
   // Synchroniser: the FSM only ever looks at s, never at din_raw.
   // ---------------------------------------------------------------------------
   sync_chain #(
      .STAGES (SYNC_STAGES),
      .INIT   (INIT_LEVEL)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .a_in  (din_raw),
      .s_out (s)
   );

   // ---------------------------------------------------------------------------
   // State, counter and output registers. All outputs come straight from these
   // flops; the pulses and stable are computed one cycle ahead in the
   // next-state logic so they line up with the d update.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RESET_STATE;
         cnt        <= '0;
         d          <= INIT_LEVEL;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         stable     <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         d          <= d_nxt;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
         stable     <= stable_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state / next-output logic.
   // The counter is cleared on every exit from a CHECK state, so it never
   // reaches values above CNT_LAST and cannot wrap.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default before the case so no
      // path leaves one unassigned, which would otherwise infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      d_nxt     = d;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;

      unique case (state)
         STABLE_LO: begin
            cnt_nxt = '0;
            if (s) begin
               state_nxt = CHECK_HI;
               cnt_nxt   = CNT_ONE;
            end
         end

         CHECK_HI: begin
            if (!s) begin
               // Bounce back to the old level: drop the candidate silently.
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
               d_nxt     = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         STABLE_HI: begin
            cnt_nxt = '0;
            if (!s) begin
               state_nxt = CHECK_LO;
               cnt_nxt   = CNT_ONE;
            end
         end

         CHECK_LO: begin
            if (s) begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
               d_nxt     = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         default: begin
            state_nxt = RESET_STATE;
            cnt_nxt   = '0;
         end
      endcase

      // stable is registered alongside state, so it is derived from the state
      // being entered rather than the current one.
      stable_nxt = is_stable_state(state_nxt);
   end

endmodule : d_input_debouncer

// File: tb/tb_d_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_d_input_debouncer
// Directed bench for d_input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// INIT_LEVEL=0 and a 10 ns clock. Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns after a rising edge. "Edge k" below is the k-th
// rising edge after an input change, the first one sampling the new level.
// -----------------------------------------------------------------------------
module tb_d_input_debouncer;

   logic clk;
   logic reset;
   logic din_raw;
   logic d;
   logic rise_pulse;
   logic fall_pulse;
   logic stable;

   int n_cmp = 0;
   int n_err = 0;

   d_input_debouncer #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .INIT_LEVEL      (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .din_raw    (din_raw),
      .d          (d),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .stable     (stable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic e_d, input logic e_r,
                             input logic e_f, input logic e_s);
      check({tag, " d"},      8'(d),          8'(e_d));
      check({tag, " rise"},   8'(rise_pulse), 8'(e_r));
      check({tag, " fall"},   8'(fall_pulse), 8'(e_f));
      check({tag, " stable"}, 8'(stable),     8'(e_s));
   endtask

   // Input moves to lvl and holds: d commits on edge 6 with a single pulse,
   // CHECK state occupied after edges 3..5.
   task automatic clean_edge(input string tag, input logic lvl);
      din_raw = lvl;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         check_outs($sformatf("%s e%0d", tag, k),
                    (k >= 6) ? lvl : ~lvl,
                    lvl && (k == 6),
                    !lvl && (k == 6),
                    !(k >= 3 && k <= 5));
      end
   endtask

   // Input high for hi clocks (hi < 4) then low: never commits; CHECK_HI
   // occupied after edges 3..hi+2.
   task automatic glitch(input string tag, input int hi);
      for (int k = 1; k <= 8; k++) begin
         din_raw = (k <= hi);
         cyc();
         check_outs($sformatf("%s e%0d", tag, k), 1'b0, 1'b0, 1'b0,
                    !(k >= 3 && k <= hi + 2));
      end
   endtask

   initial begin
      logic bounce_seq [6]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      // stable after bounce edges 1..14: CHECK_HI after 3, 5-6, 8-10.
      logic bounce_stab [14]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int   rise_count;

      // ---- 1. reset held with din_raw toggling -------------------------------
      reset   = 1'b1;
      din_raw = 1'b0;
      #1 reset = 1'b0;
      #1 check_outs("rst t2", 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         din_raw = ~din_raw;
         cyc();
         check_outs($sformatf("rst e%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      din_raw = 1'b0;
      reset   = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         check_outs($sformatf("idle e%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      end

      // ---- 2. clean rise, then clean fall back to 0 ----------------------------
      clean_edge("rise", 1'b1);
      clean_edge("fall0", 1'b0);

      // ---- 3. glitches: 3 clocks (drops on last sample) and 1 clock ----------
      glitch("glitch3", 3);
      glitch("glitch1", 1);

      // ---- 4. bounce 1,0,1,1,0,1 then held 1: final 0->1 sample at edge 6,
      //         so d commits at edge 11 ------------------------------------------
      rise_count = 0;
      for (int k = 1; k <= 14; k++) begin
         din_raw = (k <= 6) ? bounce_seq[k-1] : 1'b1;
         cyc();
         if (rise_pulse) rise_count++;
         check_outs($sformatf("bounce e%0d", k), (k >= 11), (k == 11), 1'b0,
                    bounce_stab[k-1]);
      end
      check("bounce rise_count", 8'(rise_count), 8'd1);

      // ---- 5. clean fall from d=1 ------------------------------------------------
      clean_edge("fall", 1'b0);

      // ---- 6. reset in CHECK_HI with cnt=2, then full latency again ----------
      din_raw = 1'b1;
      for (int k = 1; k <= 4; k++) cyc();
      check("midchk cnt_before", 8'(dut.cnt), 8'd2);
      check("midchk stable_before", 8'(stable), 8'd0);
      #2 reset = 1'b0;
      #1;
      check_outs("midchk rst", 1'b0, 1'b0, 1'b0, 1'b1);
      check("midchk cnt", 8'(dut.cnt), 8'd0);
      cyc();
      check_outs("midchk rst held", 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      clean_edge("postrst", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_d_input_debouncer
